instr_mem_loader: RTL

- Writer side of the instruction-memory programming port used by the fetch stage.
- Takes a byte stream from the debug UART receiver and assembles bytes big-endian into NBITS-wide words.
- Drives word-aligned byte addresses, instruction data and a one-cycle write strobe into instruction memory.
- Stops on a HALT word or when memory is full, then reports done and status to the debug unit.

---
 rtl/debug_pkg.sv | 21 ++
 rtl/instr_mem_loader_assembler.sv | 40 ++++
 rtl/instr_mem_loader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug-side instruction memory loader:
// state encodings, terminator constant and capacity helper.
package debug_pkg;

   localparam int unsigned BYTE_W = 8;

   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } loader_state_t;

   // Instruction memory holds whole 4-byte words only.
   function automatic int unsigned capacity_words(input int unsigned tam_bytes);
      return tam_bytes / 32'd4;
   endfunction

endpackage

// File: rtl/instr_mem_loader_assembler.sv
// Big-endian byte-to-word shifter with a 2-bit byte index; word_ready
// flags the cycle in which the fourth byte of a word is accepted.
module byte_word_assembler
   import debug_pkg::*;
#(
   parameter int unsigned NBITS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              accept,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [NBITS-1:0]  word,
   output logic              word_ready
);

   logic [NBITS-1:0] word_r;
   logic [1:0]       idx_r;

   assign word       = word_r;
   assign word_ready = accept && (idx_r == 2'd3);

   // Shift register and byte index; the index wraps to 0 after the fourth byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_r <= '0;
         idx_r  <= 2'd0;
      end else if (clear) begin
         word_r <= '0;
         idx_r  <= 2'd0;
      end else if (accept) begin
         word_r <= {word_r[NBITS-BYTE_W-1:0], byte_in};
         idx_r  <= idx_r + 2'd1;
      end else begin
         word_r <= word_r;
         idx_r  <= idx_r;
      end
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: assembles UART bytes into words and writes them
// at consecutive word addresses until a HALT word or memory capacity is reached.
module instr_mem_loader
   import debug_pkg::*;
#(
   parameter int unsigned        NBITS     = 32,
   parameter int unsigned        TAM_I     = 256,
   parameter logic [NBITS-1:0]   HALT_WORD = NBITS'(HALT_WORD_DEFAULT)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic              i_byte_valid,
   input  logic [BYTE_W-1:0] i_byte,
   output logic [NBITS-1:0]  o_address_memory_ins,
   output logic [NBITS-1:0]  o_instruction,
   output logic              o_write_intruc,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_full,
   output logic [7:0]        o_word_count
);

   localparam int unsigned CAPACITY = capacity_words(TAM_I);
   localparam logic [7:0]  CAP_W    = 8'(CAPACITY);

   loader_state_t    state_r, state_next;
   logic [NBITS-1:0] addr_r, addr_next;
   logic [7:0]       count_r, count_next;
   logic             full_r, full_next;
   logic             write_r, busy_r, done_r;

   logic             clear_s;
   logic             accept_s;
   logic             word_ready_s;
   logic [NBITS-1:0] word_s;
   logic             halt_s;
   logic             last_s;

   assign halt_s = (word_s == HALT_WORD);
   assign last_s = ((count_r + 8'd1) == CAP_W);

   // A byte arriving during WRITE starts the next word unless the session ends.
   assign accept_s = i_byte_valid &&
                     ((state_r == ST_RECV) ||
                      ((state_r == ST_WRITE) && !halt_s && !last_s));

   byte_word_assembler #(
      .NBITS (NBITS)
   ) u_assembler (
      .clk        (i_clk),
      .rst_n      (i_reset),
      .clear      (clear_s),
      .accept     (accept_s),
      .byte_in    (i_byte),
      .word       (word_s),
      .word_ready (word_ready_s)
   );

   // State, address, word count and full flag registers.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_r <= ST_IDLE;
         addr_r  <= '0;
         count_r <= 8'd0;
         full_r  <= 1'b0;
      end else begin
         state_r <= state_next;
         addr_r  <= addr_next;
         count_r <= count_next;
         full_r  <= full_next;
      end
   end

   // Next-state logic; start is only honoured outside an active session.
   always_comb begin
      state_next = state_r;
      addr_next  = addr_r;
      count_next = count_r;
      full_next  = full_r;
      clear_s    = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (i_start) begin
               state_next = ST_RECV;
               addr_next  = '0;
               count_next = 8'd0;
               full_next  = 1'b0;
               clear_s    = 1'b1;
            end else begin
               state_next = state_r;
            end
         end
         ST_RECV: begin
            if (word_ready_s) begin
               state_next = ST_WRITE;
            end else begin
               state_next = ST_RECV;
            end
         end
         ST_WRITE: begin
            addr_next  = addr_r + NBITS'(4);
            count_next = count_r + 8'd1;
            if (halt_s) begin
               state_next = ST_DONE;
            end else if (last_s) begin
               state_next = ST_DONE;
               full_next  = 1'b1;
            end else begin
               state_next = ST_RECV;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Strobe and status flags are registered from the next state.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         write_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         write_r <= (state_next == ST_WRITE);
         busy_r  <= (state_next == ST_RECV) || (state_next == ST_WRITE);
         done_r  <= (state_next == ST_DONE);
      end
   end

   assign o_address_memory_ins = addr_r;
   assign o_instruction        = word_s;
   assign o_write_intruc       = write_r;
   assign o_busy               = busy_r;
   assign o_done               = done_r;
   assign o_full               = full_r;
   assign o_word_count         = count_r;

endmodule
